// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that gives one shared FIFO write port to NREQ producers in bounded bursts.
// Define WR_ARB_STATS_EN to add per-requester accepted-word counters, exported on wr_count.
//
// state | meaning
// IDLE  | no grant; picks the next requester after last_owner (one-cycle bubble)
// BURST | owner holds the write port until it drops req or MAX_BURST words are written

module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           ack,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DW-1:0]             fifo_wr_data,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
`ifdef WR_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0]     wr_count
`endif
);

  localparam int OW = $clog2(NREQ);
  localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

  if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1 || MAX_BURST > 15 || CNT_W < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [OW-1:0]   last_owner;
  logic [OW-1:0]   next_owner;
  logic [3:0]      burst_cnt;
  logic            wr;
  logic            found;
  int              idx;

  // Scan starts one past the previous owner so every requester gets a turn.
  always_comb begin
    next_owner = last_owner;
    found      = 1'b0;
    idx        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_owner) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        next_owner = OW'(idx);
      end
    end
  end

  always_comb begin
    wr           = (state == BURST) && req[owner] && !fifo_full;
    fifo_wr_en   = wr;
    ack          = '0;
    fifo_wr_data = '0;
    if (wr) begin
      ack[owner]   = 1'b1;
      fifo_wr_data = req_data[owner*DW +: DW];
    end
  end

  assign busy = (state == BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(NREQ - 1);
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner     <= next_owner;
            state     <= BURST;
            burst_cnt <= '0;
          end
        end
        BURST: begin
          // A full FIFO only stalls; dropping req or finishing the burst releases.
          if (!req[owner] || (wr && burst_cnt == LAST_CNT)) begin
            state      <= IDLE;
            last_owner <= owner;
          end else if (wr) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WR_ARB_STATS_EN
  logic [CNT_W-1:0] cnt [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt_out
    assign wr_count[gi*CNT_W +: CNT_W] = cnt[gi];
  end
`endif

endmodule
